controller_fsm_group_ctx_simd: RTL and testbench
================================================

Name: controller_fsm_group_ctx_simd

Overview:
Parameterised nested-loop iteration controller for the SIMD datapath. It holds per-group loop-bound tables and drives an odometer-style iteration vector under an explicit IDLE/RUN/DONE state machine. It adds suspend/resume with per-group context save/restore, a configurable group count, and config-error reporting. It sits between the instruction decoder (config writes) and the SIMD address generators (iteration consumers).

Parameters:
LOOP_ID_W, 3, loop index width; NUM_LOOPS = 1<<LOOP_ID_W
GROUP_ID_W, 2, group index width
NUM_GROUPS, 4, implemented groups (1..1<<GROUP_ID_W); group ids >= NUM_GROUPS are dropped and set cfg_err
LOOP_ITER_W, 16, iteration counter / bound width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_loop_iter_v  in  1  bound write strobe
cfg_loop_iter  in  LOOP_ITER_W  bound = trip count - 1
cfg_loop_group_id  in  GROUP_ID_W  target group of bound write
block_done  in  1  clear all bound tables and saved contexts
start  in  1  start request (accepted in IDLE only)
resume  in  1  qualifies start: restore saved context if present
group_id  in  GROUP_ID_W  group to run, sampled with start
stall  in  1  consumer back-pressure
suspend  in  1  save context and return to IDLE
busy  out  1  state != IDLE
iter_v  out  1  current_iters valid and consumed this cycle
current_iters  out  LOOP_ITER_W*NUM_LOOPS  loop l at bits [LOOP_ITER_W*l +: LOOP_ITER_W]
iter_last  out  NUM_LOOPS  per-loop wrap flag for the current vector
done  out  1  one-cycle completion pulse
suspended  out  1  one-cycle suspend-acknowledge pulse
cfg_err  out  1  sticky illegal-config flag
cfg_overflow  out  1  sticky flag for more than NUM_LOOPS writes to one group

Behaviour:
- Reset: every output is 0. State goes to IDLE. All write pointers, bound-valid bits and ctx_valid bits clear.
- Config: each group has a write pointer wp[g]. A write stores cfg_loop_iter into bound[g][wp[g]], sets valid, and increments wp[g]. Loop 0 is outermost; loop NUM_LOOPS-1 is innermost.
- When wp[g] == NUM_LOOPS, further writes are dropped and cfg_overflow is set.
- Unwritten loops have a bound of 0, i.e. one trip.
- While busy, writes to the active group are dropped and set cfg_err. Writes to other groups proceed.
- block_done in IDLE clears all wp, valid and ctx_valid bits. block_done while busy is dropped and sets cfg_err.
- A start and a config write to the same group in the same cycle: start uses the pre-write table.
- start together with block_done in IDLE: the clear takes effect first, so the run uses all-zero bounds and produces exactly one iteration (all zeros).
- IDLE -> RUN on start:
  - Latch group_id and copy the bound table into the active max registers.
  - If resume && ctx_valid[g], load iters from ctx[g]; otherwise load 0.
  - start is ignored in RUN and DONE.
- RUN:
  - iter_v = ~stall & ~suspend. Handshake: a vector is consumed on any cycle with iter_v=1.
  - iter_last[i] = (iter[i] == max[i]) & iter_last[i+1]; the term beyond the innermost loop is 1.
  - On consume: if iter_last[0], go to DONE. Otherwise increment the innermost loop whose iter_last is 0, and zero every loop inside it.
  - Counters hold on stall.
- Suspend: in RUN, suspend has priority over stall and consume. The current, unconsumed vector is saved to ctx[g], ctx_valid[g] is set, suspended pulses, and the state goes to IDLE. A later resume re-issues that vector first.
- DONE: lasts one cycle. done=1, busy=1, ctx_valid[g] cleared, then IDLE. current_iters holds its last value until the next start.
- Latency:
  - start at cycle T gives the first vector at T+1.
  - Last consume at cycle X gives done at X+1, with busy low from X+2.
  - Minimum run (all bounds 0) is 3 cycles from start to IDLE.
- Reset mid-run: state returns to IDLE immediately, all contexts are lost, and no done pulse is issued.
- Arithmetic: iteration counters are unsigned, compared for equality only, and never wrap past max.

Test Plan:
- Group 1 bounds {1,2} (loop 0 = 1, loop 1 = 2), start, no stall -> 6 vectors (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on cycles T+1..T+6; done at T+7; busy low at T+8.
- Same run with stall high on cycles T+2..T+4 -> iter_v low on those cycles; the vector sequence is unchanged; done at T+10.
- Group 2 bounds {3}, suspend asserted while iters = 2 -> suspended pulses, IDLE. Start with resume=1 -> vectors 2, 3, then done. Start again with resume=1 -> starts from 0 (context was cleared at done).
- Nine writes to group 0 with LOOP_ID_W=3 -> first 8 stored; cfg_overflow=1. A write to the active group while busy -> cfg_err=1 and the bound is unchanged.
- start and block_done in the same IDLE cycle -> exactly one vector of all zeros, then done.
- Assert reset during RUN -> all outputs 0 next cycle; a subsequent start with resume=1 starts from 0.

Source files
------------

// File: rtl/controller_fsm_group_ctx_simd.sv
// Nested-loop iteration controller: per-group bound tables, odometer iteration vector,
// suspend/resume with per-group saved context, and sticky config-error reporting.
module controller_fsm_group_ctx_simd #(
    parameter int unsigned LOOP_ID_W   = 3,
    parameter int unsigned GROUP_ID_W  = 2,
    parameter int unsigned NUM_GROUPS  = 4,
    parameter int unsigned LOOP_ITER_W = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0]                 cfg_loop_iter,
    input  logic [GROUP_ID_W-1:0]                  cfg_loop_group_id,
    input  logic                                   block_done,
    input  logic                                   start,
    input  logic                                   resume,
    input  logic [GROUP_ID_W-1:0]                  group_id,
    input  logic                                   stall,
    input  logic                                   suspend,
    output logic                                   busy,
    output logic                                   iter_v,
    output logic [LOOP_ITER_W*(1<<LOOP_ID_W)-1:0]  current_iters,
    output logic [(1<<LOOP_ID_W)-1:0]              iter_last,
    output logic                                   done,
    output logic                                   suspended,
    output logic                                   cfg_err,
    output logic                                   cfg_overflow
);
    localparam int unsigned NUM_LOOPS   = 1 << LOOP_ID_W;
    localparam int unsigned GROUP_SLOTS = 1 << GROUP_ID_W;
    localparam int unsigned WP_W        = LOOP_ID_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [GROUP_ID_W-1:0]   act_g;
    logic [LOOP_ITER_W-1:0]  bound   [GROUP_SLOTS][NUM_LOOPS];
    logic [NUM_LOOPS-1:0]    bound_v [GROUP_SLOTS];
    logic [WP_W-1:0]         wp      [GROUP_SLOTS];
    logic [LOOP_ITER_W-1:0]  ctx     [GROUP_SLOTS][NUM_LOOPS];
    logic [GROUP_SLOTS-1:0]  ctx_valid;
    logic [LOOP_ITER_W-1:0]  max_r   [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0]  iter_r  [NUM_LOOPS];

    logic [NUM_LOOPS:0]      last_chain;
    logic                    consume;
    logic                    clear_c;
    logic [LOOP_ID_W-1:0]    wp_idx;

    function automatic logic group_ok(input logic [GROUP_ID_W-1:0] g);
        return 32'(g) < NUM_GROUPS;
    endfunction

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign consume = (state == RUN) && !stall && !suspend;
    assign iter_v  = consume;
    assign clear_c = block_done && (state == IDLE);
    assign wp_idx  = wp[cfg_loop_group_id][LOOP_ID_W-1:0];

    // Wrap chain: a loop wraps only when it and every loop inside it are at max.
    always_comb begin
        last_chain            = '0;
        last_chain[NUM_LOOPS] = 1'b1;
        for (int l = NUM_LOOPS - 1; l >= 0; l--) begin
            last_chain[l] = (iter_r[l] == max_r[l]) && last_chain[l+1];
        end
    end

    assign iter_last = (state == RUN) ? last_chain[NUM_LOOPS-1:0] : '0;

    always_comb begin
        current_iters = '0;
        for (int l = 0; l < NUM_LOOPS; l++) begin
            current_iters[LOOP_ITER_W*l +: LOOP_ITER_W] = iter_r[l];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            act_g        <= '0;
            suspended    <= 1'b0;
            cfg_err      <= 1'b0;
            cfg_overflow <= 1'b0;
            ctx_valid    <= '0;
            for (int g = 0; g < GROUP_SLOTS; g++) begin
                wp[g]      <= '0;
                bound_v[g] <= '0;
            end
            for (int l = 0; l < NUM_LOOPS; l++) begin
                max_r[l]  <= '0;
                iter_r[l] <= '0;
            end
        end else begin
            suspended <= 1'b0;

            // Bound-table write; a same-cycle clear wins over the write.
            if (cfg_loop_iter_v && !clear_c) begin
                if (!group_ok(cfg_loop_group_id) || (busy && cfg_loop_group_id == act_g)) begin
                    cfg_err <= 1'b1;
                end else if (wp[cfg_loop_group_id] == WP_W'(NUM_LOOPS)) begin
                    cfg_overflow <= 1'b1;
                end else begin
                    bound[cfg_loop_group_id][wp_idx]   <= cfg_loop_iter;
                    bound_v[cfg_loop_group_id][wp_idx] <= 1'b1;
                    wp[cfg_loop_group_id]              <= wp[cfg_loop_group_id] + 1'b1;
                end
            end

            if (block_done) begin
                if (clear_c) begin
                    ctx_valid <= '0;
                    for (int g = 0; g < GROUP_SLOTS; g++) begin
                        wp[g]      <= '0;
                        bound_v[g] <= '0;
                    end
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (!group_ok(group_id)) begin
                            cfg_err <= 1'b1;
                        end else begin
                            act_g <= group_id;
                            state <= RUN;
                            for (int l = 0; l < NUM_LOOPS; l++) begin
                                max_r[l]  <= (block_done || !bound_v[group_id][l])
                                             ? '0 : bound[group_id][l];
                                iter_r[l] <= (resume && ctx_valid[group_id] && !block_done)
                                             ? ctx[group_id][l] : '0;
                            end
                        end
                    end
                end
                RUN: begin
                    if (suspend) begin
                        for (int l = 0; l < NUM_LOOPS; l++) begin
                            ctx[act_g][l] <= iter_r[l];
                        end
                        ctx_valid[act_g] <= 1'b1;
                        suspended        <= 1'b1;
                        state            <= IDLE;
                    end else if (consume) begin
                        if (last_chain[0]) begin
                            state <= DONE;
                        end else begin
                            // Bump the innermost non-wrapping loop, zero those inside it.
                            for (int l = 0; l < NUM_LOOPS; l++) begin
                                if (last_chain[l]) begin
                                    iter_r[l] <= '0;
                                end else if (last_chain[l+1]) begin
                                    iter_r[l] <= LOOP_ITER_W'(iter_r[l] + 1'b1);
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    ctx_valid[act_g] <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_controller_fsm_group_ctx_simd.sv
// Directed bench for controller_fsm_group_ctx_simd with hand-computed expected vectors.
module tb_controller_fsm_group_ctx_simd;
    localparam int unsigned LOOP_ID_W   = 3;
    localparam int unsigned GROUP_ID_W  = 2;
    localparam int unsigned NUM_GROUPS  = 4;
    localparam int unsigned LOOP_ITER_W = 16;
    localparam int unsigned NUM_LOOPS   = 1 << LOOP_ID_W;

    logic                              clk = 1'b0;
    logic                              reset;
    logic                              cfg_loop_iter_v;
    logic [LOOP_ITER_W-1:0]            cfg_loop_iter;
    logic [GROUP_ID_W-1:0]             cfg_loop_group_id;
    logic                              block_done;
    logic                              start;
    logic                              resume;
    logic [GROUP_ID_W-1:0]             group_id;
    logic                              stall;
    logic                              suspend;
    logic                              busy;
    logic                              iter_v;
    logic [LOOP_ITER_W*NUM_LOOPS-1:0]  current_iters;
    logic [NUM_LOOPS-1:0]              iter_last;
    logic                              done;
    logic                              suspended;
    logic                              cfg_err;
    logic                              cfg_overflow;

    int n_cmp = 0;
    int n_err = 0;

    controller_fsm_group_ctx_simd #(
        .LOOP_ID_W(LOOP_ID_W), .GROUP_ID_W(GROUP_ID_W),
        .NUM_GROUPS(NUM_GROUPS), .LOOP_ITER_W(LOOP_ITER_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_iter(cfg_loop_iter),
        .cfg_loop_group_id(cfg_loop_group_id), .block_done(block_done),
        .start(start), .resume(resume), .group_id(group_id),
        .stall(stall), .suspend(suspend),
        .busy(busy), .iter_v(iter_v), .current_iters(current_iters),
        .iter_last(iter_last), .done(done), .suspended(suspended),
        .cfg_err(cfg_err), .cfg_overflow(cfg_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int g, input int val);
        cfg_loop_iter_v   = 1'b1;
        cfg_loop_group_id = GROUP_ID_W'(g);
        cfg_loop_iter     = LOOP_ITER_W'(val);
        cyc();
        cfg_loop_iter_v   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        #1;
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_iterv"}, 128'(iter_v), 128'(0));
        check_eq({tag, "_iters"}, 128'(current_iters), 128'(0));
        check_eq({tag, "_last"}, 128'(iter_last), 128'(0));
        check_eq({tag, "_done"}, 128'(done), 128'(0));
        check_eq({tag, "_susp"}, 128'(suspended), 128'(0));
        check_eq({tag, "_err"}, 128'(cfg_err), 128'(0));
        check_eq({tag, "_ovf"}, 128'(cfg_overflow), 128'(0));
    endtask

    // Expected contents of loops 0 and 1 for linear index idx (other loops at 0, bound 0).
    task automatic check_vec(input string tag, input int idx, input int lim0, input int lim1);
        logic [127:0]         exp_iters;
        logic [NUM_LOOPS-1:0] exp_last;
        int l0, l1;
        l0 = idx / (lim1 + 1);
        l1 = idx % (lim1 + 1);
        exp_iters        = '0;
        exp_iters[15:0]  = 16'(l0);
        exp_iters[31:16] = 16'(l1);
        exp_last         = '1;
        exp_last[1]      = (l1 == lim1);
        exp_last[0]      = (l0 == lim0) && (l1 == lim1);
        check_eq({tag, "_iters"}, 128'(current_iters), exp_iters);
        check_eq({tag, "_last"}, 128'(iter_last), 128'(exp_last));
    endtask

    // Full run from start cycle T; stall_mask bit k stalls cycle T+k; wr_off injects a write to gid.
    task automatic run_seq(input string tag, input int gid, input logic rsm, input logic bd,
                           input logic [31:0] stall_mask, input int first_idx,
                           input int lim0, input int lim1, input int exp_done_off, input int wr_off);
        int idx, off, total;
        start      = 1'b1;
        group_id   = GROUP_ID_W'(gid);
        resume     = rsm;
        block_done = bd;
        cyc();
        start      = 1'b0;
        resume     = 1'b0;
        block_done = 1'b0;
        idx   = first_idx;
        total = (lim0 + 1) * (lim1 + 1);
        off   = 1;
        while (idx < total && off < 40) begin
            stall = stall_mask[off];
            if (off == wr_off) begin
                cfg_loop_iter_v   = 1'b1;
                cfg_loop_group_id = GROUP_ID_W'(gid);
                cfg_loop_iter     = 16'd5;
            end
            #1;
            check_eq({tag, "_iterv"}, 128'(iter_v), 128'(!stall_mask[off]));
            check_vec(tag, idx, lim0, lim1);
            if (!stall_mask[off]) idx++;
            cyc();
            stall           = 1'b0;
            cfg_loop_iter_v = 1'b0;
            off++;
        end
        #1;
        check_eq({tag, "_done_cycle"}, 128'(off), 128'(exp_done_off));
        check_eq({tag, "_done"}, 128'(done), 128'(1));
        check_eq({tag, "_busy_done"}, 128'(busy), 128'(1));
        cyc();
        check_eq({tag, "_idle"}, 128'(busy), 128'(0));
        check_eq({tag, "_done_off"}, 128'(done), 128'(0));
    endtask

    // Start gid from zero, consume n vectors, suspend on the next one.
    task automatic run_suspend(input string tag, input int gid, input int n);
        start    = 1'b1;
        group_id = GROUP_ID_W'(gid);
        resume   = 1'b0;
        cyc();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            #1;
            check_vec(tag, k, 3, 0);
            cyc();
        end
        suspend = 1'b1;
        #1;
        check_eq({tag, "_iterv_susp"}, 128'(iter_v), 128'(0));
        check_vec(tag, n, 3, 0);
        cyc();
        suspend = 1'b0;
        #1;
        check_eq({tag, "_suspended"}, 128'(suspended), 128'(1));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        cyc();
        check_eq({tag, "_suspended_pulse"}, 128'(suspended), 128'(0));
    endtask

    initial begin
        reset = 1'b1; cfg_loop_iter_v = 1'b0; cfg_loop_iter = '0; cfg_loop_group_id = '0;
        block_done = 1'b0; start = 1'b0; resume = 1'b0; group_id = '0;
        stall = 1'b0; suspend = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        check_quiet("reset");

        // Group 1 bounds {1,2}: plain run, then stalled run.
        wr(1, 1);
        wr(1, 2);
        run_seq("g1_plain", 1, 1'b0, 1'b0, 32'h0, 0, 1, 2, 7, 0);
        run_seq("g1_stall", 1, 1'b0, 1'b0, 32'h1C, 0, 1, 2, 10, 0);

        // Group 2 bound {3}: suspend at 2, resume, then resume again after context cleared.
        wr(2, 3);
        run_suspend("g2_susp", 2, 2);
        run_seq("g2_resume", 2, 1'b1, 1'b0, 32'h0, 2, 3, 0, 3, 0);
        run_seq("g2_again", 2, 1'b1, 1'b0, 32'h0, 0, 3, 0, 5, 0);

        // Nine writes to group 0: overflow only on the ninth.
        for (int k = 0; k < 8; k++) wr(0, 10 + k);
        #1;
        check_eq("ovf_after8", 128'(cfg_overflow), 128'(0));
        wr(0, 18);
        #1;
        check_eq("ovf_after9", 128'(cfg_overflow), 128'(1));
        check_eq("err_before_busy_wr", 128'(cfg_err), 128'(0));

        // Write to active group while busy: dropped, cfg_err set, table unchanged on rerun.
        run_seq("g1_busywr", 1, 1'b0, 1'b0, 32'h0, 0, 1, 2, 7, 1);
        check_eq("err_busy_wr", 128'(cfg_err), 128'(1));
        run_seq("g1_recheck", 1, 1'b0, 1'b0, 32'h0, 0, 1, 2, 7, 0);

        // start with block_done: clear first, single all-zero vector.
        run_seq("bd_start", 1, 1'b0, 1'b1, 32'h0, 0, 0, 0, 2, 0);
        run_seq("bd_after", 1, 1'b0, 1'b0, 32'h0, 0, 0, 0, 2, 0);

        // Reset mid-run after a resume; context must be lost.
        wr(2, 3);
        run_suspend("g2_susp2", 2, 2);
        start = 1'b1; group_id = 2'd2; resume = 1'b1;
        cyc();
        start = 1'b0; resume = 1'b0;
        #1;
        check_vec("rst_pre", 2, 3, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_quiet("rst_mid");
        wr(2, 3);
        run_seq("rst_resume", 2, 1'b1, 1'b0, 32'h0, 0, 3, 0, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
